// File: rtl/window_pkg.sv
// Shared types for the window feeder: default kernel limit, window layout,
// FSM states and the kernel-size legality rule.
package window_pkg;

    localparam int MAX_KERNEL_DEF = 7;

    typedef logic [MAX_KERNEL_DEF-1:0][MAX_KERNEL_DEF-1:0][7:0] window_t;

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;

    // Odd, at least 3, and small enough to fit both the window and the image.
    function automatic logic kernel_legal(input int k, input int max_k,
                                          input int w, input int h);
        return (k >= 3) && (k % 2 == 1) && (k <= max_k) && (k <= w) && (k <= h);
    endfunction

endpackage

// File: rtl/window_feeder_line_buffer.sv
// Ring of pixel lines with one shared column address; o_rd_dat[r] is the line
// that sits r lines after the write slot, i.e. oldest line first, read before write.
module line_buffer #(
    parameter int LINES = 6,
    parameter int WIDTH = 64
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clr,
    input  logic [$clog2(LINES+1)-1:0]     i_nlines,
    input  logic [$clog2(WIDTH)-1:0]       i_col,
    input  logic                           i_wr_en,
    input  logic                           i_eol,
    input  logic [7:0]                     i_wr_dat,
    output logic [LINES-1:0][7:0]          o_rd_dat
);
    localparam int LW = $clog2(LINES+1);

    logic [7:0]    r_mem [LINES][WIDTH];
    logic [LW-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_wr_en && i_eol) begin
            r_ptr <= (r_ptr + LW'(1) >= i_nlines) ? '0 : r_ptr + LW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_ptr][i_col] <= i_wr_dat;
        end
    end

    // Slot arithmetic is modulo the active line count, so only k-1 lines rotate.
    always_comb begin
        o_rd_dat = '0;
        for (int r = 0; r < LINES; r++) begin
            int s;
            s = int'(r_ptr) + r;
            if (s >= int'(i_nlines)) s = s - int'(i_nlines);
            if (r < int'(i_nlines)) o_rd_dat[r] = r_mem[LW'(s)][i_col];
        end
    end

endmodule

// File: rtl/window_feeder.sv
// Raster pixel stream to k x k interior windows with a start/done handshake;
// start follows the completing pixel by one cycle, input stalls only while a window is outstanding.
module window_feeder
    import window_pkg::*;
#(
    parameter int MAX_KERNEL = MAX_KERNEL_DEF,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
)(
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [$clog2(MAX_KERNEL)-1:0]                 i_kernel_size,
    input  logic                                          i_frame_start,
    input  logic [7:0]                                    i_pixel_in,
    input  logic                                          i_pixel_valid,
    output logic                                          o_pixel_ready,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]    o_window,
    output logic                                          o_start,
    input  logic                                          i_done,
    output logic [$clog2(IMG_WIDTH)-1:0]                  o_out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0]                 o_out_y,
    output logic                                          o_frame_done,
    output logic                                          o_err
);
    localparam int KW    = $clog2(MAX_KERNEL);
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int LINES = MAX_KERNEL - 1;
    localparam int LW    = $clog2(LINES+1);

    state_t                                     r_state, w_state_nxt;
    logic [KW-1:0]                              r_k;
    logic [XW-1:0]                              r_x, r_out_x;
    logic [YW-1:0]                              r_y, r_out_y;
    logic                                       r_err, r_last, r_frame_done;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_window, w_win_nxt;
    logic [LINES-1:0][7:0]                      w_lb;
    logic [MAX_KERNEL-1:0][7:0]                 w_col;
    logic [LW-1:0]                              w_nlines;
    logic                                       w_k_ok, w_frame_go, w_accept, w_issue;
    logic                                       w_x_last, w_y_last;
    int                                         w_k;

    assign w_k        = int'(r_k);
    assign w_nlines   = (w_k > 0) ? LW'(w_k - 1) : '0;
    assign w_k_ok     = kernel_legal(int'(i_kernel_size), MAX_KERNEL, IMG_WIDTH, IMG_HEIGHT);
    assign w_frame_go = (r_state == IDLE) && i_frame_start && w_k_ok;
    assign w_accept   = (r_state == FILL) && i_pixel_valid;
    assign w_x_last   = (r_x == XW'(IMG_WIDTH - 1));
    assign w_y_last   = (r_y == YW'(IMG_HEIGHT - 1));
    assign w_issue    = w_accept && (int'(r_x) >= w_k - 1) && (int'(r_y) >= w_k - 1);

    line_buffer #(.LINES(LINES), .WIDTH(IMG_WIDTH)) u_lb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_frame_go),
        .i_nlines (w_nlines),
        .i_col    (r_x),
        .i_wr_en  (w_accept),
        .i_eol    (w_x_last),
        .i_wr_dat (i_pixel_in),
        .o_rd_dat (w_lb)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_pixel_ready = 1'b0;
        o_start       = 1'b0;
        case (r_state)
            IDLE:  if (w_frame_go) w_state_nxt = FILL;
            FILL: begin
                o_pixel_ready = 1'b1;
                if (w_issue) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                o_start     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT:  if (i_done) w_state_nxt = r_last ? IDLE : FILL;
            default: w_state_nxt = IDLE;
        endcase
    end

    // New column: older lines from the buffer, the live pixel in row k-1.
    always_comb begin
        w_col = {8'h00, w_lb};
        if (w_k > 0) w_col[KW'(w_k - 1)] = i_pixel_in;
        w_win_nxt = '0;
        for (int r = 0; r < MAX_KERNEL; r++) begin
            logic [MAX_KERNEL-1:0][7:0] w_row;
            w_row = r_window[r] >> 8;
            for (int c = 0; c < MAX_KERNEL; c++) begin
                if (r < w_k && c < w_k) begin
                    w_win_nxt[r][c] = (c == w_k - 1) ? w_col[r] : w_row[c];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_err        <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_window     <= '0;
        end else begin
            r_frame_done <= (r_state == WAIT) && i_done && r_last;
            if (r_state == IDLE && i_frame_start) begin
                if (w_k_ok) begin
                    r_k    <= i_kernel_size;
                    r_x    <= '0;
                    r_y    <= '0;
                    r_err  <= 1'b0;
                    r_last <= 1'b0;
                end else begin
                    r_err  <= 1'b1;
                end
            end
            if (w_accept) begin
                r_window <= w_win_nxt;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
                if (w_issue) begin
                    r_out_x <= r_x - XW'(w_k - 1);
                    r_out_y <= r_y - YW'(w_k - 1);
                    r_last  <= w_x_last && w_y_last;
                end
            end
        end
    end

    assign o_window     = r_window;
    assign o_out_x      = r_out_x;
    assign o_out_y      = r_out_y;
    assign o_frame_done = r_frame_done;
    assign o_err        = r_err;

endmodule
